// File: rtl/arm_mc_controller.sv
// Multicycle ARM control unit: registered main FSM, NZCV flag store and
// per-instruction latched condition result driving the datapath strobes.
module arm_mc_controller #(
    parameter int unsigned ALUCW = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [19:0]      Instr,
    input  logic [3:0]       ALUFlags,
    output logic             PCWrite,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             IRWrite,
    output logic             AdrSrc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ImmSrc,
    output logic [1:0]       RegSrc,
    output logic [ALUCW-1:0] ALUControl,
    output logic [3:0]       State,
    output logic [3:0]       Flags
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        UNKNOWN  = 4'd10
    } state_t;

    state_t      state_q, state_n;
    logic        condexr;
    logic        condex;
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic        next_pc, ir_w, reg_w, mem_w, alu_op, branch;
    logic [2:0]  alu_dec;
    logic [1:0]  flag_w;
    logic        no_write, pcs;
    logic        unused_instr;

    assign cond  = Instr[19:16];
    assign op    = Instr[15:14];
    assign funct = Instr[13:8];
    assign rd    = Instr[3:0];
    assign unused_instr = ^Instr[7:4];

    // State, flag store and latched condition result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            Flags   <= 4'b0000;
            condexr <= 1'b0;
        end else begin
            state_q <= state_n;
            if (state_q == DECODE) begin
                condexr <= condex;
            end
            if (state_q == EXECUTER || state_q == EXECUTEI) begin
                if (flag_w[1] && condexr) Flags[3:2] <= ALUFlags[3:2];
                if (flag_w[0] && condexr) Flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    // Next state and raw per-state controls
    always_comb begin
        state_n   = FETCH;
        next_pc   = 1'b0;
        ir_w      = 1'b0;
        reg_w     = 1'b0;
        mem_w     = 1'b0;
        alu_op    = 1'b0;
        branch    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        case (state_q)
            FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                ir_w      = 1'b1;
                next_pc   = 1'b1;
                state_n   = DECODE;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (op)
                    2'b01:   state_n = MEMADR;
                    2'b00:   state_n = funct[5] ? EXECUTEI : EXECUTER;
                    2'b10:   state_n = BRANCH;
                    default: state_n = UNKNOWN;
                endcase
            end
            MEMADR: begin
                ALUSrcB = 2'b01;
                state_n = funct[0] ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc  = 1'b1;
                state_n = MEMWB;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                reg_w     = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc = 1'b1;
                mem_w  = 1'b1;
            end
            EXECUTER: begin
                alu_op  = 1'b1;
                state_n = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcB = 2'b01;
                alu_op  = 1'b1;
                state_n = ALUWB;
            end
            ALUWB: begin
                reg_w = 1'b1;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            default: state_n = FETCH;
        endcase
    end

    // ALU opcode decode and immediate/register source selects
    always_comb begin
        alu_dec = 3'd0;
        case (funct[4:1])
            4'b0100:          alu_dec = 3'd0;
            4'b0010, 4'b1010: alu_dec = 3'd1;
            4'b0000:          alu_dec = 3'd2;
            4'b1100:          alu_dec = 3'd3;
            4'b1101:          alu_dec = 3'd4;
            default:          alu_dec = 3'd0;
        endcase
        case (op)
            2'b01:   begin ImmSrc = 2'b01; RegSrc = 2'b10; end
            2'b10:   begin ImmSrc = 2'b10; RegSrc = 2'b01; end
            default: begin ImmSrc = 2'b00; RegSrc = 2'b00; end
        endcase
    end

    // Condition evaluation against the stored flags {N,Z,C,V}
    always_comb begin
        condex = 1'b0;
        case (cond)
            4'b0000: condex = Flags[2];
            4'b0001: condex = ~Flags[2];
            4'b0010: condex = Flags[1];
            4'b0011: condex = ~Flags[1];
            4'b0100: condex = Flags[3];
            4'b0101: condex = ~Flags[3];
            4'b0110: condex = Flags[0];
            4'b0111: condex = ~Flags[0];
            4'b1000: condex = Flags[1] & ~Flags[2];
            4'b1001: condex = ~(Flags[1] & ~Flags[2]);
            4'b1010: condex = (Flags[3] == Flags[0]);
            4'b1011: condex = (Flags[3] != Flags[0]);
            4'b1100: condex = ~Flags[2] & (Flags[3] == Flags[0]);
            4'b1101: condex = ~(~Flags[2] & (Flags[3] == Flags[0]));
            4'b1110: condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

    assign ALUControl = alu_op ? ALUCW'(alu_dec) : '0;
    assign flag_w[1]  = alu_op & funct[0];
    assign flag_w[0]  = flag_w[1] & (alu_dec < 3'd2);
    assign no_write   = (funct[4:1] == 4'b1010);
    assign pcs        = ((rd == 4'b1111) & reg_w) | branch;

    // Write strobes are held off while reset is asserted
    assign PCWrite  = ~reset & (next_pc | (pcs & condexr));
    assign RegWrite = ~reset & reg_w & condexr & ~no_write;
    assign MemWrite = ~reset & mem_w & condexr;
    assign IRWrite  = ~reset & ir_w;
    assign State    = state_q;

endmodule
